comp_mac_pipe: RTL and testbench

//   Parametrised, fully pipelined multi-channel multiplier/accumulator.

---
 rtl/comp_pkg.sv | 17 +
 rtl/comp_mac_lane.sv | 85 ++++++++
 rtl/comp_mac_pipe.sv | 75 +++++++
 tb/tb_comp_mac_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the comp MAC family: sample mode encoding and lane bus packing helpers.
package comp_pkg;

  typedef enum logic {
    MODE_PROD = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  function automatic int unsigned lane_base(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned res_width(input int unsigned p_size);
    return 2 * p_size;
  endfunction

endpackage

// File: rtl/comp_mac_lane.sv
// One MAC lane: operand register, exact product, delay line and saturating accumulator with sticky flag.
module comp_mac_lane
  import comp_pkg::*;
#(
  parameter int unsigned P_SIZE  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [P_SIZE-1:0]            i_a,
  input  logic [P_SIZE-1:0]            i_b,
  input  logic                         fin_vld,
  input  logic                         fin_mode,
  input  logic                         fin_clr,
  output logic [res_width(P_SIZE)-1:0] o_res,
  output logic                         o_sat
);

  localparam int unsigned W = res_width(P_SIZE);

  logic [P_SIZE-1:0] a_r, b_r;
  logic [W-1:0]      prod_fin;
  logic [W-1:0]      acc;
  logic [W:0]        sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= i_a;
      b_r <= i_b;
    end
  end

  if (LATENCY == 2) begin : g_merge
    // Product feeds the accumulate register combinationally when the stages merge.
    assign prod_fin = W'(a_r) * W'(b_r);
  end else begin : g_pipe
    for (genvar i = 0; i < LATENCY - 2; i++) begin : g_dly
      logic [W-1:0] q;
      if (i == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q <= '0;
          else     q <= W'(a_r) * W'(b_r);
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q <= '0;
          else     q <= g_dly[i-1].q;
        end
      end
    end
    assign prod_fin = g_dly[LATENCY-3].q;
  end

  // Carry out of the widened sum is exactly the overflow condition.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, prod_fin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      o_res <= '0;
      o_sat <= 1'b0;
    end else if (fin_vld) begin
      if (fin_mode == MODE_PROD) begin
        o_res <= prod_fin;
      end else if (fin_clr) begin
        acc   <= prod_fin;
        o_res <= prod_fin;
        o_sat <= 1'b0;
      end else if (sum[W]) begin
        acc   <= '1;
        o_res <= '1;
        o_sat <= 1'b1;
      end else begin
        acc   <= sum[W-1:0];
        o_res <= sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/comp_mac_pipe.sv
// Multi-lane pipelined multiplier/accumulator: shared control pipeline plus N_CH generated lanes.
module comp_mac_pipe
  import comp_pkg::*;
#(
  parameter int unsigned P_SIZE  = 8,
  parameter int unsigned N_CH    = 2,
  parameter int unsigned LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       i_mode,
  input  logic                       i_clr,
  input  logic [N_CH*P_SIZE-1:0]     i_param,
  input  logic [N_CH*P_SIZE-1:0]     i_param_2,
  output logic [N_CH*2*P_SIZE-1:0]   o_param,
  output logic [N_CH-1:0]            o_sat,
  output logic                       dv
);

  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-2:0] mode_sr;
  logic [LATENCY-2:0] clr_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[LATENCY-2:0], ena};
  end

  // Mode/clr only need to reach the accumulate stage, one slot short of dv.
  if (LATENCY == 2) begin : g_ctl_short
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_sr <= '0;
        clr_sr  <= '0;
      end else begin
        mode_sr <= i_mode;
        clr_sr  <= i_clr;
      end
    end
  end else begin : g_ctl_long
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_sr <= '0;
        clr_sr  <= '0;
      end else begin
        mode_sr <= {mode_sr[LATENCY-3:0], i_mode};
        clr_sr  <= {clr_sr[LATENCY-3:0], i_clr};
      end
    end
  end

  assign dv = vld_sr[LATENCY-1];

  for (genvar n = 0; n < N_CH; n++) begin : g_lane
    localparam int unsigned OP_LO  = lane_base(n, P_SIZE);
    localparam int unsigned RES_LO = lane_base(n, res_width(P_SIZE));

    comp_mac_lane #(
      .P_SIZE  (P_SIZE),
      .LATENCY (LATENCY)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_a      (i_param[OP_LO +: P_SIZE]),
      .i_b      (i_param_2[OP_LO +: P_SIZE]),
      .fin_vld  (vld_sr[LATENCY-2]),
      .fin_mode (mode_sr[LATENCY-2]),
      .fin_clr  (clr_sr[LATENCY-2]),
      .o_res    (o_param[RES_LO +: res_width(P_SIZE)]),
      .o_sat    (o_sat[n])
    );
  end

endmodule

// File: tb/tb_comp_mac_pipe.sv
// Self-checking bench for comp_mac_pipe (P_SIZE=4, N_CH=2, LATENCY=3) with a behavioural expectation model.
module tb_comp_mac_pipe;

  localparam int unsigned P   = 4;
  localparam int unsigned NC  = 2;
  localparam int unsigned LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ena = 1'b0;
  logic              i_mode = 1'b0;
  logic              i_clr = 1'b0;
  logic [NC*P-1:0]   i_param = '0;
  logic [NC*P-1:0]   i_param_2 = '0;
  logic [NC*2*P-1:0] o_param;
  logic [NC-1:0]     o_sat;
  logic              dv;

  comp_mac_pipe #(
    .P_SIZE  (P),
    .N_CH    (NC),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .i_mode    (i_mode),
    .i_clr     (i_clr),
    .i_param   (i_param),
    .i_param_2 (i_param_2),
    .o_param   (o_param),
    .o_sat     (o_sat),
    .dv        (dv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic [1:0]  sat;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          started = 1'b0;
  exp_t        exp_q[int];
  logic [17:0] lit_q[$];
  int          m_acc[NC];
  bit          m_sat[NC];
  logic [15:0] last_out = '0;
  logic [1:0]  last_sat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    lit_q.delete();
    for (int n = 0; n < NC; n++) begin
      m_acc[n] = 0;
      m_sat[n] = 1'b0;
    end
    last_out = '0;
    last_sat = '0;
  endtask

  // One input slot; the model resolves the sample at issue time since results come out in order.
  task automatic drive(input logic e, input logic m, input logic c,
                       input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input logic [15:0] lit, input logic [1:0] lit_sat);
    int   a[NC];
    int   b[NC];
    int   p;
    int   s;
    exp_t ex;
    @(posedge clk);
    #1;
    ena       = e;
    i_mode    = m;
    i_clr     = c;
    i_param   = {a1, a0};
    i_param_2 = {b1, b0};
    a[0] = int'(a0); b[0] = int'(b0);
    a[1] = int'(a1); b[1] = int'(b1);
    if (e) begin
      ex = '0;
      for (int n = 0; n < NC; n++) begin
        p = a[n] * b[n];
        if (!m) begin
          ex.out[n*8 +: 8] = 8'(p);
        end else if (c) begin
          m_acc[n] = p;
          m_sat[n] = 1'b0;
          ex.out[n*8 +: 8] = 8'(p);
        end else begin
          s = m_acc[n] + p;
          if (s > 255) begin
            m_acc[n] = 255;
            m_sat[n] = 1'b1;
          end else begin
            m_acc[n] = s;
          end
          ex.out[n*8 +: 8] = 8'(m_acc[n]);
        end
        ex.sat[n] = m_sat[n];
      end
      exp_q[cyc + LAT] = ex;
      lit_q.push_back({lit_sat, lit});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 2'b00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ena = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] l;
    if (started) begin
      if (exp_q.exists(cyc)) begin
        e = exp_q[cyc];
        exp_q.delete(cyc);
        chk("dv_high", 32'(dv), 32'd1);
        chk("model_out", 32'(o_param), 32'(e.out));
        chk("model_sat", 32'(o_sat), 32'(e.sat));
        last_out = e.out;
        last_sat = e.sat;
        if (lit_q.size() > 0) begin
          l = lit_q.pop_front();
          chk("pin_out", 32'(o_param), 32'(l[15:0]));
          chk("pin_sat", 32'(o_sat), 32'(l[17:16]));
        end else begin
          chk("pin_missing", 32'd0, 32'd1);
        end
      end else begin
        chk("dv_low", 32'(dv), 32'd0);
        chk("hold_out", 32'(o_param), 32'(last_out));
        chk("hold_sat", 32'(o_sat), 32'(last_sat));
      end
    end
  end

  initial begin
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    chk("reset_dv", 32'(dv), 32'd0);
    chk("reset_out", 32'(o_param), 32'd0);
    chk("reset_sat", 32'(o_sat), 32'd0);

    // product
    drive(1, 0, 0, 4'd3, 4'd2, 4'd15, 4'd15, 16'hE106, 2'b00);
    idle(5);

    // streaming
    drive(1, 0, 0, 4'd1, 4'd2, 4'd0, 4'd0, 16'h0002, 2'b00);
    drive(1, 0, 0, 4'd2, 4'd2, 4'd0, 4'd0, 16'h0004, 2'b00);
    drive(1, 0, 0, 4'd3, 4'd2, 4'd0, 4'd0, 16'h0006, 2'b00);
    drive(1, 0, 0, 4'd4, 4'd2, 4'd0, 4'd0, 16'h0008, 2'b00);
    idle(5);

    // accumulate, saturate, stay saturated, clear
    drive(1, 1, 1, 4'd10, 4'd10, 4'd1, 4'd1, 16'h0164, 2'b00);
    drive(1, 1, 0, 4'd10, 4'd10, 4'd1, 4'd1, 16'h02C8, 2'b00);
    drive(1, 1, 0, 4'd10, 4'd10, 4'd1, 4'd1, 16'h03FF, 2'b01);
    drive(1, 1, 0, 4'd10, 4'd10, 4'd1, 4'd1, 16'h04FF, 2'b01);
    idle(2);
    drive(1, 1, 1, 4'd10, 4'd10, 4'd1, 4'd1, 16'h0164, 2'b00);
    idle(5);

    // bubble carrying mode=1/clr=1 must be ignored
    drive(1, 1, 1, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0101, 2'b00);
    drive(0, 1, 1, 4'd7, 4'd7, 4'd7, 4'd7, 16'h0000, 2'b00);
    drive(1, 1, 0, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0202, 2'b00);
    idle(5);

    // mode mix; clr on a product sample must not touch the accumulator
    drive(1, 1, 1, 4'd10, 4'd5, 4'd0, 4'd0, 16'h0032, 2'b00);
    drive(1, 0, 1, 4'd3, 4'd3, 4'd2, 4'd3, 16'h0609, 2'b00);
    drive(1, 1, 0, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0133, 2'b00);
    idle(5);

    // reset with a sample in flight
    drive(1, 0, 0, 4'd3, 4'd2, 4'd15, 4'd15, 16'hE106, 2'b00);
    do_reset();
    idle(6);
    drive(1, 0, 0, 4'd3, 4'd2, 4'd15, 4'd15, 16'hE106, 2'b00);
    idle(6);

    chk("pending_exp", 32'(exp_q.size()), 32'd0);
    chk("pending_pin", 32'(lit_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
